// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and the select-width helper for the parameterised register
// file (param_regfile) and its read multiplexer (regfile_read_mux).
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Ceiling log2. The loop is bounded so that it elaborates to a constant.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// regfile_read_mux
// One combinational read port of param_regfile.
// Ports:
//   sel      - read select index
//   din      - external bus, returned when sel is 0
//   mem      - flattened storage array (entry 0 is unused)
//   vld      - per-entry written flags (bit 0 is unused)
//   byp_en   - a write to this same index is in flight this cycle
//   byp_data - data of that in-flight write
//   data     - read data
//   valid    - read valid
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SELW  = clog2(DEPTH)
) (
  input  logic [SELW-1:0]             sel,
  input  logic [WIDTH-1:0]            din,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            vld,
  input  logic                        byp_en,
  input  logic [WIDTH-1:0]            byp_data,
  output logic [WIDTH-1:0]            data,
  output logic                        valid
);

  always_comb begin
    data  = '0;
    valid = 1'b0;
    if (byp_en) begin
      data  = byp_data;
      valid = 1'b1;
    end else if (sel == '0) begin
      data  = din;
      valid = 1'b1;
    end else begin
      data  = mem[sel];
      valid = vld[sel];
    end
  end

endmodule

// File: rtl/param_regfile.sv
// param_regfile
// Register file with DEPTH-1 storage words (indices 1..DEPTH-1), one write
// port and two independent zero-latency read ports. Index 0 has no storage:
// reading it returns the external bus DIN with valid=1, writing it is a no-op.
// Optional macro: REGFILE_WRITE_BYPASS_EN forwards an in-flight write to any
// read port selecting the same index in the same cycle.
// Ports:
//   CLK          - clock, rising edge
//   RST          - asynchronous active-low reset
//   WE/DSEL/RIN  - write enable, destination index, write data
//   CLR          - synchronous clear of all words and valid flags (beats WE)
//   ASEL/BSEL    - read selects
//   DIN          - external bus for select 0
//   ABUS/BBUS    - read data
//   AVALID/BVALID- selected word written since last reset/clear
module param_regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int SELW  = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [SELW-1:0]  DSEL,
  input  logic [WIDTH-1:0] RIN,
  input  logic             CLR,
  input  logic [SELW-1:0]  ASEL,
  input  logic [SELW-1:0]  BSEL,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] ABUS,
  output logic [WIDTH-1:0] BBUS,
  output logic             AVALID,
  output logic             BVALID
);

  // Entry 0 is never written, so it stays at reset value and costs nothing
  // once optimised; keeping it lets the mux index directly with the select.
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            vld;
  logic                        byp_a;
  logic                        byp_b;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem <= '0;
      vld <= '0;
    end else if (CLR) begin
      mem <= '0;
      vld <= '0;
    end else if (WE && (DSEL != '0)) begin
      mem[DSEL] <= RIN;
      vld[DSEL] <= 1'b1;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic wr_live;
  // RST is part of the term so an asserted reset never forwards a write.
  assign wr_live = RST && WE && !CLR && (DSEL != '0);
  assign byp_a   = wr_live && (ASEL == DSEL);
  assign byp_b   = wr_live && (BSEL == DSEL);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  regfile_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW)) u_rd_a (
    .sel      (ASEL),
    .din      (DIN),
    .mem      (mem),
    .vld      (vld),
    .byp_en   (byp_a),
    .byp_data (RIN),
    .data     (ABUS),
    .valid    (AVALID)
  );

  regfile_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW)) u_rd_b (
    .sel      (BSEL),
    .din      (DIN),
    .mem      (mem),
    .vld      (vld),
    .byp_en   (byp_b),
    .byp_data (RIN),
    .data     (BBUS),
    .valid    (BVALID)
  );

endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile
// Self-checking bench for param_regfile: directed scenarios on a 16x8 and a
// 32x16 instance, then randomized traffic on the 16x8 instance compared every
// cycle against an array-based reference model.
`timescale 1ns/1ps
module tb_param_regfile;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, we, clr;
  logic [2:0]  dsel, asel, bsel;
  logic [15:0] rin, din, abus, bbus;
  logic        avalid, bvalid;

  logic        rst1, we1, clr1;
  logic [3:0]  dsel1, asel1, bsel1;
  logic [31:0] rin1, din1, abus1, bbus1;
  logic        avalid1, bvalid1;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #20 clk = ~clk;

  param_regfile u_dut (
    .CLK(clk), .RST(rst), .WE(we), .DSEL(dsel), .RIN(rin), .CLR(clr),
    .ASEL(asel), .BSEL(bsel), .DIN(din),
    .ABUS(abus), .BBUS(bbus), .AVALID(avalid), .BVALID(bvalid)
  );

  param_regfile #(.WIDTH(32), .DEPTH(16)) u_dut32 (
    .CLK(clk), .RST(rst1), .WE(we1), .DSEL(dsel1), .RIN(rin1), .CLR(clr1),
    .ASEL(asel1), .BSEL(bsel1), .DIN(din1),
    .ABUS(abus1), .BBUS(bbus1), .AVALID(avalid1), .BVALID(bvalid1)
  );

  // Reference model: contents and written-flags of each index.
  logic [15:0] m_mem [8];
  bit          m_vld [8];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i] <= '0;
        m_vld[i] <= 1'b0;
      end
    end else if (clr) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i] <= '0;
        m_vld[i] <= 1'b0;
      end
    end else if (we && dsel != 3'd0) begin
      m_mem[dsel] <= rin;
      m_vld[dsel] <= 1'b1;
    end
  end

  function automatic logic [16:0] model_rd(input logic [2:0] s);
    if (BYP && rst && we && !clr && dsel != 3'd0 && s == dsel) return {1'b1, rin};
    if (s == 3'd0) return {1'b1, din};
    return {m_vld[s], m_mem[s]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] ea, eb;
    if (chk_en) begin
      ea = model_rd(asel);
      eb = model_rd(bsel);
      chk("cyc_abus",   abus,   {16'h0, ea[15:0]});
      chk("cyc_avalid", avalid, {31'h0, ea[16]});
      chk("cyc_bbus",   bbus,   {16'h0, eb[15:0]});
      chk("cyc_bvalid", bvalid, {31'h0, eb[16]});
    end
  end

  initial begin
    logic [16:0] pin;
    rst = 1'b0; we = 1'b0; clr = 1'b0; dsel = '0; rin = '0;
    asel = 3'd3; bsel = 3'd0; din = 16'hBEEF;
    rst1 = 1'b0; we1 = 1'b0; clr1 = 1'b0; dsel1 = '0; rin1 = '0;
    asel1 = 4'd15; bsel1 = 4'd0; din1 = 32'h0BAD_F00D;
    #3;
    chk("rst_abus",   abus,   16'h0);
    chk("rst_avalid", avalid, 1'b0);
    chk("rst_bbus",   bbus,   16'hBEEF);
    chk("rst_bvalid", bvalid, 1'b1);
    chk("rst32_abus", abus1,  32'h0);
    chk("rst32_bbus", bbus1,  32'h0BAD_F00D);

    @(posedge clk); #2;
    rst = 1'b1; rst1 = 1'b1; chk_en = 1'b1;

    // write then read
    we = 1'b1; dsel = 3'd5; rin = 16'h1234; asel = 3'd5;
    #1;
    chk("wr_same_cyc_abus",   abus,   BYP ? 16'h1234 : 16'h0);
    chk("wr_same_cyc_avalid", avalid, BYP);
    @(posedge clk); #2;
    we = 1'b0;
    #1;
    chk("wr_abus",   abus,   16'h1234);
    chk("wr_avalid", avalid, 1'b1);
    pin = model_rd(3'd5);
    chk("model_pin_5", {15'h0, pin}, {15'h0, 1'b1, 16'h1234});

    // write to index 0 is ignored
    we = 1'b1; dsel = 3'd0; rin = 16'hFFFF; asel = 3'd0; din = 16'h00AA;
    @(posedge clk); #2;
    we = 1'b0;
    #1;
    chk("idx0_abus",   abus,   16'h00AA);
    chk("idx0_avalid", avalid, 1'b1);
    for (int i = 1; i < 8; i++) begin
      asel = 3'(i);
      #1;
      chk("idx0_keep_data",  abus,   (i == 5) ? 16'h1234 : 16'h0);
      chk("idx0_keep_valid", avalid, (i == 5) ? 1'b1 : 1'b0);
    end

    // load 1..7, then clear with a simultaneous write
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #2;
      we = 1'b1; dsel = 3'(i); rin = 16'($urandom) | 16'h0001;
    end
    @(posedge clk); #2;
    we = 1'b1; clr = 1'b1; dsel = 3'd2; rin = 16'h5555;
    @(posedge clk); #2;
    we = 1'b0; clr = 1'b0;
    for (int i = 1; i < 8; i++) begin
      asel = 3'(i); bsel = 3'(i);
      #1;
      chk("clr_abus",   abus,   16'h0);
      chk("clr_avalid", avalid, 1'b0);
      chk("clr_bbus",   bbus,   16'h0);
      chk("clr_bvalid", bvalid, 1'b0);
    end

    // same-cycle forwarding to both ports
    @(posedge clk); #2;
    we = 1'b1; dsel = 3'd4; rin = 16'hA5A5; asel = 3'd4; bsel = 3'd4;
    #1;
    chk("byp_abus",   abus,   BYP ? 16'hA5A5 : 16'h0);
    chk("byp_bbus",   bbus,   BYP ? 16'hA5A5 : 16'h0);
    chk("byp_avalid", avalid, BYP);
    chk("byp_bvalid", bvalid, BYP);
    @(posedge clk); #2;
    we = 1'b0;
    #1;
    chk("byp_after_abus", abus, 16'hA5A5);

    // reset asserted mid-write discards the write
    we = 1'b1; dsel = 3'd3; rin = 16'h7777; asel = 3'd3; bsel = 3'd4;
    #3;
    rst = 1'b0;
    @(posedge clk); #2;
    we = 1'b0; rst = 1'b1;
    #1;
    chk("rstwr_abus",   abus,   16'h0);
    chk("rstwr_avalid", avalid, 1'b0);
    chk("rstwr_bbus",   bbus,   16'h0);

    // 32x16 instance
    we1 = 1'b1; dsel1 = 4'd15; rin1 = 32'hDEADBEEF;
    @(posedge clk); #2;
    we1 = 1'b0; asel1 = 4'd15; bsel1 = 4'd15;
    #1;
    chk("p32_abus",   abus1,   32'hDEADBEEF);
    chk("p32_bbus",   bbus1,   32'hDEADBEEF);
    chk("p32_avalid", avalid1, 1'b1);
    chk("p32_bvalid", bvalid1, 1'b1);
    for (int i = 1; i < 15; i++) begin
      asel1 = 4'(i);
      #1;
      chk("p32_other", {avalid1, abus1[30:0]}, 32'h0);
    end

    // randomized traffic
    repeat (600) begin
      @(posedge clk); #2;
      we   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 31) == 0);
      dsel = 3'($urandom_range(0, 7));
      rin  = 16'($urandom);
      din  = 16'($urandom);
      asel = ($urandom_range(0, 3) == 0) ? dsel : 3'($urandom_range(0, 7));
      bsel = ($urandom_range(0, 3) == 0) ? dsel : 3'($urandom_range(0, 7));
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 63) == 0) rst = 1'b0;
    end

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
